// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execution stage.
// Results are 64-bit signed so full products and -2^31 / -1 fit without overflow.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, DIVIDE, OUTPUT, DONE} exec_state_t;

    // Unsigned magnitude of a signed operand; -2^31 maps to 2^31.
    function automatic logic [31:0] magnitude(operand_t v);
        return v[31] ? 32'(-v) : 32'(v);
    endfunction

endpackage

// File: rtl/instr_divider.sv
// Restoring serial divider on 32-bit magnitudes; signs are applied to the final
// quotient (truncate toward zero) and remainder (sign of the dividend).
module instr_divider
    import instr_register_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     load,
    input  operand_t dividend,
    input  operand_t divisor,
    output result_t  quotient,
    output result_t  remainder,
    output logic     div_done
);

    localparam int CW = $clog2(DIV_ITER + 1);

    logic          active;
    logic [CW-1:0] iter;
    logic [31:0]   quo, rem, dvs;
    logic          neg_q, neg_r;
    logic [32:0]   shifted;
    logic          fits;

    assign shifted = {rem, quo[31]};
    assign fits    = shifted >= {1'b0, dvs};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active <= 1'b0;
            iter   <= '0;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (load) begin
            active <= 1'b1;
            iter   <= CW'(DIV_ITER);
            quo    <= magnitude(dividend);
            rem    <= '0;
            dvs    <= magnitude(divisor);
            neg_q  <= dividend[31] ^ divisor[31];
            neg_r  <= dividend[31];
        end else if (active) begin
            if (iter != '0) begin
                rem  <= fits ? 32'(shifted - {1'b0, dvs}) : shifted[31:0];
                quo  <= {quo[30:0], fits};
                iter <= iter - CW'(1);
            end else begin
                active <= 1'b0;
            end
        end
    end

    assign div_done  = active && (iter == '0);
    assign quotient  = neg_q ? -result_t'({32'd0, quo}) : result_t'({32'd0, quo});
    assign remainder = neg_r ? -result_t'({32'd0, rem}) : result_t'({32'd0, rem});

endmodule

// File: rtl/instr_register.sv
// 32-entry instruction register file: synchronous write, combinational read.
module instr_register
    import instr_register_pkg::*;
(
    input  logic         clk,
    input  logic         load_en,
    input  logic         reset_n,
    input  operand_t     operand_a,
    input  operand_t     operand_b,
    input  opcode_t      opcode,
    input  logic [4:0]   write_pointer,
    input  logic [4:0]   read_pointer,
    output instruction_t instruction_word
);

    instruction_t iw_reg [32];

    // NOTE: the array is reset on purpose so reads before any write return ZERO rather than X;
    // sequential state is always written with <= so every entry updates on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) iw_reg[i] <= '0;
        end else if (load_en) begin
            iw_reg[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_b};
        end
    end

    assign instruction_word = iw_reg[read_pointer];

endmodule

// File: rtl/top_exec.sv
// Netlist pairing the instruction register with its execution stage.
module top_exec
    import instr_register_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_en,
    input  operand_t   operand_a,
    input  operand_t   operand_b,
    input  opcode_t    opcode,
    input  logic [4:0] write_pointer,
    input  logic       start,
    input  logic [4:0] start_ptr,
    input  logic [5:0] count,
    input  logic       res_ready,
    output logic       busy,
    output logic       res_valid,
    output result_t    res_data,
    output opcode_t    res_opcode,
    output logic [4:0] res_ptr,
    output logic       res_err,
    output logic       done
);

    logic [4:0]   read_pointer;
    instruction_t instruction_word;

    instr_register u_reg (
        .clk              (clk),
        .load_en          (load_en),
        .reset_n          (reset_n),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .opcode           (opcode),
        .write_pointer    (write_pointer),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word)
    );

    instr_exec_unit u_exec (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .start_ptr        (start_ptr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .busy             (busy),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_opcode       (res_opcode),
        .res_ptr          (res_ptr),
        .res_err          (res_err),
        .done             (done)
    );

endmodule

// File: rtl/instr_exec_unit.sv
// Execution stage: walks a window of the instruction register, computes each
// opcode result and presents it on a registered valid/ready port.
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [4:0]   start_ptr,
    input  logic [5:0]   count,
    output logic [4:0]   read_pointer,
    input  instruction_t instruction_word,
    output logic         busy,
    output logic         res_valid,
    input  logic         res_ready,
    output result_t      res_data,
    output opcode_t      res_opcode,
    output logic [4:0]   res_ptr,
    output logic         res_err,
    output logic         done
);

    exec_state_t  state, state_next;
    logic [4:0]   ptr;
    logic [5:0]   remaining;
    instruction_t iw_q;
    result_t      a64, b64, single_res, quotient, remainder;
    logic         is_div, div_by_zero, div_load, div_done;

    assign a64         = result_t'(iw_q.op_a);
    assign b64         = result_t'(iw_q.op_b);
    assign is_div      = iw_q.opc inside {DIV, MOD};
    assign div_by_zero = iw_q.op_b == '0;
    assign div_load    = (state == EXEC) && is_div && !div_by_zero;

    instr_divider #(.DIV_ITER(DIV_ITER)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (div_load),
        .dividend  (iw_q.op_a),
        .divisor   (iw_q.op_b),
        .quotient  (quotient),
        .remainder (remainder),
        .div_done  (div_done)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        single_res = '0;
        case (iw_q.opc)
            PASSA:   single_res = a64;
            PASSB:   single_res = b64;
            ADD:     single_res = a64 + b64;
            SUB:     single_res = a64 - b64;
            MULT:    single_res = a64 * b64;
            default: single_res = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (count != 6'd0) ? FETCH : DONE;
            FETCH:   state_next = EXEC;
            EXEC:    state_next = div_load ? DIVIDE : OUTPUT;
            DIVIDE:  if (div_done) state_next = OUTPUT;
            OUTPUT:  if (res_ready) state_next = (remaining == 6'd1) ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Status flags are registered from the next state so no output depends on res_ready combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            done       <= 1'b0;
            ptr        <= '0;
            remaining  <= '0;
            iw_q       <= '0;
            res_data   <= '0;
            res_opcode <= ZERO;
            res_ptr    <= '0;
            res_err    <= 1'b0;
        end else begin
            busy      <= state_next != IDLE;
            res_valid <= state_next == OUTPUT;
            done      <= state_next == DONE;
            case (state)
                IDLE: if (start && count != 6'd0) begin
                    ptr       <= start_ptr;
                    remaining <= count;
                end
                FETCH: iw_q <= instruction_word;
                EXEC: begin
                    res_data   <= single_res;
                    res_opcode <= iw_q.opc;
                    res_ptr    <= ptr;
                    res_err    <= is_div && div_by_zero;
                end
                DIVIDE: if (div_done) res_data <= (iw_q.opc == DIV) ? quotient : remainder;
                OUTPUT: if (res_ready) begin
                    ptr       <= ptr + 5'd1;
                    remaining <= remaining - 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign read_pointer = ptr;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Self-checking bench for instr_exec_unit: directed corner cases plus random
// instruction windows checked against a plain-arithmetic reference model.
module tb_instr_exec_unit;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [4:0]   start_ptr = '0;
    logic [5:0]   count = '0;
    logic         res_ready = 1'b0;
    logic [4:0]   read_pointer;
    instruction_t instruction_word;
    logic         busy, res_valid, res_err, done;
    result_t      res_data;
    opcode_t      res_opcode;
    logic [4:0]   res_ptr;

    instruction_t mem [32];
    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    assign instruction_word = mem[read_pointer];

    instr_exec_unit #(.DIV_ITER(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .start_ptr        (start_ptr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .busy             (busy),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_opcode       (res_opcode),
        .res_ptr          (res_ptr),
        .res_err          (res_err),
        .done             (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour straight from the opcode definitions, using 64-bit integer arithmetic.
    function automatic void model(input instruction_t iw, output longint d, output bit e);
        longint a = iw.op_a;
        longint b = iw.op_b;
        d = 0;
        e = 1'b0;
        case (iw.opc)
            PASSA: d = a;
            PASSB: d = b;
            ADD:   d = a + b;
            SUB:   d = a - b;
            MULT:  d = a * b;
            DIV:   if (b == 0) e = 1'b1; else d = a / b;
            MOD:   if (b == 0) e = 1'b1; else d = a % b;
            default: d = 0;
        endcase
    endfunction

    function automatic instruction_t mk(input int opc, input operand_t a, input operand_t b);
        return '{opc: opcode_t'(4'(opc)), op_a: a, op_b: b};
    endfunction

    function automatic operand_t rand_op();
        case ($urandom_range(7))
            0:       return 32'sh8000_0000;
            1:       return -32'sd1;
            2:       return 32'sd0;
            3:       return 32'sd1;
            4:       return 32'sh7fff_ffff;
            default: return operand_t'($urandom);
        endcase
    endfunction

    // One run: start, then consume every result with the given ready policy and check it.
    task automatic run(input int sp, input int cnt, input int pct, input int stall_idx,
                       input int stall_len, input bit chk_lat, input bit chk_gap, input bit glitch);
        int idx = 0;
        int cyc = 1;
        int last_valid = 0;
        int stalled = 0;
        int p;
        bit holding = 1'b0;
        logic [79:0] snap = '0;
        logic [79:0] now;
        longint exp_d;
        bit exp_e;
        instruction_t iw;
        @(negedge clk);
        start = 1'b1; start_ptr = 5'(sp); count = 6'(cnt);
        @(negedge clk);
        start = 1'b0;
        while (idx < cnt && cyc < 3000) begin
            now = {res_data, 4'(res_opcode), res_ptr, res_err, read_pointer, res_valid};
            if (holding) check("stall_hold", now, snap);
            if (res_valid && !holding) begin
                p = (sp + idx) % 32;
                iw = mem[p];
                model(iw, exp_d, exp_e);
                if (idx == 0 && chk_lat)
                    check("latency", 64'(cyc), (iw.opc inside {DIV, MOD} && iw.op_b != 0) ? 64'd36 : 64'd3);
                if (idx > 0 && chk_gap) check("issue_gap", 64'(cyc - last_valid), 64'd3);
                last_valid = cyc;
                check("res_ptr", 64'(res_ptr), 64'(p));
                check("res_opcode", 64'(res_opcode), 64'(iw.opc));
                check("res_data", res_data, exp_d);
                check("res_err", 64'(res_err), 64'(exp_e));
            end
            if (res_valid) begin
                if (idx == stall_idx && stalled < stall_len) begin
                    res_ready = 1'b0;
                    stalled++;
                end else begin
                    res_ready = ($urandom_range(99) < pct);
                end
                holding = !res_ready;
                snap = now;
                if (res_ready) idx++;
            end else begin
                res_ready = 1'($urandom_range(1));
                holding = 1'b0;
            end
            if (glitch && cyc == 5) begin
                start = 1'b1; start_ptr = 5'(sp + 9); count = 6'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("all_results", 64'(idx), 64'(cnt));
        check("done_pulse", 64'(done), 64'd1);
        res_ready = 1'b0;
        @(negedge clk);
        check("done_low", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_valid", 64'(res_valid), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_data"}, res_data, 64'd0);
        check({tag, "_opcode"}, 64'(res_opcode), 64'(ZERO));
        check({tag, "_ptr"}, 64'(res_ptr), 64'd0);
        check({tag, "_err"}, 64'(res_err), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_rdptr"}, 64'(read_pointer), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset_n = 1'b1;

        // ADD with latency and ptr check
        mem[3] = mk(ADD, 32'sd7, -32'sd9);
        run(3, 1, 100, -1, 0, 1'b1, 1'b0, 1'b0);

        // Signed DIV / MOD, DIV result at cycle 36
        mem[5] = mk(DIV, -32'sd17, 32'sd5);
        mem[6] = mk(MOD, -32'sd17, 32'sd5);
        run(5, 2, 100, -1, 0, 1'b1, 1'b0, 1'b0);

        // Divide by zero finishes at cycle 3 with err
        mem[4] = mk(DIV, 32'sd100, 32'sd0);
        run(4, 1, 100, -1, 0, 1'b1, 1'b0, 1'b0);

        // Wrap 30,31,0,1 with MULT extremes, -2^31/-1, invalid opcode, 10-cycle stall on result 1
        mem[30] = mk(MULT, 32'sh8000_0000, 32'sh8000_0000);
        mem[31] = mk(SUB, 32'sd5, -32'sd3);
        mem[0]  = mk(DIV, 32'sh8000_0000, -32'sd1);
        mem[1]  = mk(12, 32'sd3, 32'sd4);
        run(30, 4, 100, 1, 10, 1'b1, 1'b0, 1'b0);

        // Back-to-back single-cycle ops issue every 3 cycles
        mem[8]  = mk(ADD, 32'sd1000, 32'sd24);
        mem[9]  = mk(SUB, -32'sd5, 32'sd7);
        mem[10] = mk(PASSA, -32'sd123, 32'sd9);
        mem[11] = mk(PASSB, 32'sd1, -32'sd77);
        run(8, 4, 100, -1, 0, 1'b1, 1'b1, 1'b0);

        // count = 0: done at cycle 1, no result
        @(negedge clk);
        start = 1'b1; start_ptr = 5'd3; count = 6'd0;
        @(negedge clk);
        start = 1'b0;
        check("cnt0_done", 64'(done), 64'd1);
        check("cnt0_valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        check("cnt0_done_low", 64'(done), 64'd0);
        check("cnt0_idle", 64'(busy), 64'd0);
        check("cnt0_valid2", 64'(res_valid), 64'd0);

        // start pulsed while busy is ignored
        mem[12] = mk(DIV, 32'sd1000, 32'sd7);
        mem[13] = mk(MOD, -32'sd1000, 32'sd7);
        run(12, 2, 100, -1, 0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset during DIVIDE, between clock edges
        @(negedge clk);
        start = 1'b1; start_ptr = 5'd5; count = 6'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1 check_reset_values("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        run(5, 2, 70, -1, 0, 1'b1, 1'b0, 1'b0);

        // Random windows against the reference model
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 32; i++)
                mem[i] = '{opc: opcode_t'(4'($urandom_range(9))), op_a: rand_op(), op_b: rand_op()};
            run($urandom_range(31), $urandom_range(1, 32), $urandom_range(30, 100), -1, 0, 1'b1, 1'b0, 1'b0);
        end

        // count = 32 visits every entry exactly once
        for (int i = 0; i < 32; i++)
            mem[i] = '{opc: opcode_t'(4'($urandom_range(9))), op_a: rand_op(), op_b: rand_op()};
        run($urandom_range(31), 32, 100, -1, 0, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1);
    end

endmodule
